mem_wb_cycle: RTL

Back end of the five-stage pipeline: registers execute-stage results into the memory stage, performs data-memory loads and stores, registers the outcome into the writeback stage, and drives the register-file write port (RegWriteW, RdW, ResultW) consumed by the decode stage. It also exports memory- and writeback-stage destination information for the hazard/forwarding unit.

---
 rtl/mem_wb_cycle.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mem_wb_cycle.sv
// -----------------------------------------------------------------------------
// mem_wb_cycle
//
// Back end of the five-stage pipeline. Registers execute-stage results into
// the memory stage (E/M register), performs data-memory loads and stores,
// registers the outcome into the writeback stage (M/W register), and drives
// the register-file write port consumed by the decode stage. Memory- and
// writeback-stage destination information is exported for the
// hazard/forwarding unit.
//
// Parameters
//   DEPTH  data-memory depth in 32-bit words (power of two)
//   AW     word-address width, log2(DEPTH)
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous, active-low reset
//   RegWriteE   in   execute-stage register-write enable
//   ResultSrcE  in   0 = ALU result, 1 = memory read data
//   MemWriteE   in   execute-stage store enable
//   ALUResultE  in   ALU result; byte address for loads and stores
//   WriteDataE  in   store data (rs2 value)
//   RdE         in   destination register
//   RegWriteM   out  memory-stage write enable (forwarding)
//   RdM         out  memory-stage destination (forwarding)
//   ALUResultM  out  memory-stage ALU result (forwarding)
//   RegWriteW   out  register-file write enable, suppressed for x0
//   RdW         out  register-file write address
//   ResultW     out  register-file write data
//
// Flow control
//   There is no handshake: no stall and no flush inputs exist, so every
//   rising edge advances both pipeline registers. A bubble is simply an
//   all-zero set of E inputs.
// -----------------------------------------------------------------------------
module mem_wb_cycle #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteE,
    input  logic        ResultSrcE,
    input  logic        MemWriteE,
    input  logic [31:0] ALUResultE,
    input  logic [31:0] WriteDataE,
    input  logic [4:0]  RdE,
    output logic        RegWriteM,
    output logic [4:0]  RdM,
    output logic [31:0] ALUResultM,
    output logic        RegWriteW,
    output logic [4:0]  RdW,
    output logic [31:0] ResultW
);

    // -------------------------------------------------------------------------
    // E/M pipeline register
    // -------------------------------------------------------------------------
    logic        reg_write_m_q,  reg_write_m_d;
    logic        result_src_m_q, result_src_m_d;
    logic        mem_write_m_q,  mem_write_m_d;
    logic [31:0] alu_result_m_q, alu_result_m_d;
    logic [31:0] write_data_m_q, write_data_m_d;
    logic [4:0]  rd_m_q,         rd_m_d;

    // Every edge advances the register unconditionally.
    always_comb begin
        reg_write_m_d  = RegWriteE;
        result_src_m_d = ResultSrcE;
        mem_write_m_d  = MemWriteE;
        alu_result_m_d = ALUResultE;
        write_data_m_d = WriteDataE;
        rd_m_d         = RdE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_m_q  <= 1'b0;
            result_src_m_q <= 1'b0;
            mem_write_m_q  <= 1'b0;
            alu_result_m_q <= 32'h0;
            write_data_m_q <= 32'h0;
            rd_m_q         <= 5'd0;
        end else begin
            reg_write_m_q  <= reg_write_m_d;
            result_src_m_q <= result_src_m_d;
            mem_write_m_q  <= mem_write_m_d;
            alu_result_m_q <= alu_result_m_d;
            write_data_m_q <= write_data_m_d;
            rd_m_q         <= rd_m_d;
        end
    end

    // -------------------------------------------------------------------------
    // Data memory
    // -------------------------------------------------------------------------
    // Only the word-index bits of the byte address are decoded: the low two
    // bits are dropped (no misalignment trap) and anything above AW+1 is
    // dropped too, so addresses wrap modulo DEPTH words.
    logic [31:0] mem_q [DEPTH];
    logic [AW-1:0] mem_idx;
    logic [31:0]   read_data_m;
    logic          mem_we;

    assign mem_idx     = alu_result_m_q[AW+1:2];
    assign read_data_m = mem_q[mem_idx];

    // MemWriteM is already cleared asynchronously by reset; the extra rst
    // term keeps a store from landing on the very edge that reset is low,
    // so memory is untouched whenever reset is asserted.
    assign mem_we = mem_write_m_q & rst;

    // The array deliberately has no reset: its contents survive rst.
    // A read and a write to the same word in one cycle sees the old data,
    // because the read is combinational off the current array contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_idx] <= write_data_m_q;
        end
    end

    // -------------------------------------------------------------------------
    // M/W pipeline register
    // -------------------------------------------------------------------------
    logic        reg_write_w_q,  reg_write_w_d;
    logic        result_src_w_q, result_src_w_d;
    logic [4:0]  rd_w_q,         rd_w_d;
    logic [31:0] alu_result_w_q, alu_result_w_d;
    logic [31:0] read_data_w_q,  read_data_w_d;

    always_comb begin
        reg_write_w_d  = reg_write_m_q;
        result_src_w_d = result_src_m_q;
        rd_w_d         = rd_m_q;
        alu_result_w_d = alu_result_m_q;
        read_data_w_d  = read_data_m;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_w_q  <= 1'b0;
            result_src_w_q <= 1'b0;
            rd_w_q         <= 5'd0;
            alu_result_w_q <= 32'h0;
            read_data_w_q  <= 32'h0;
        end else begin
            reg_write_w_q  <= reg_write_w_d;
            result_src_w_q <= result_src_w_d;
            rd_w_q         <= rd_w_d;
            alu_result_w_q <= alu_result_w_d;
            read_data_w_q  <= read_data_w_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign RegWriteM  = reg_write_m_q;
    assign RdM        = rd_m_q;
    assign ALUResultM = alu_result_m_q;

    // x0 is hard-wired to zero in the register file, so a write to it is
    // never issued even though the data path still presents the value.
    assign RegWriteW  = reg_write_w_q & (rd_w_q != 5'd0);
    assign RdW        = rd_w_q;
    assign ResultW    = result_src_w_q ? read_data_w_q : alu_result_w_q;

endmodule
